// File: rtl/rv32_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv32_pkg
// Brief    : Shared width codes and LSU state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package rv32_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } lsu_state_t;

endpackage
`default_nettype wire

// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit_if
// Brief    : Data-memory req/ack bus between the LSU and memory.
// Revision : 1.0 - initial release
// ============================================================================
interface load_store_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_align
// Brief    : Byte-lane steering, load extension and alignment check.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_align
    import rv32_pkg::*;
(
    input  wire logic [2:0]  i_req_f3,
    input  wire logic [1:0]  i_req_lo,
    input  wire logic        i_is_store,
    input  wire logic [31:0] i_alu_out,
    output logic      [3:0]  o_be,
    output logic      [31:0] o_wdata,
    output logic             o_misalign,
    input  wire logic [2:0]  i_rsp_f3,
    input  wire logic [1:0]  i_rsp_lo,
    input  wire logic [31:0] i_mem_rdata,
    output logic      [31:0] o_load_data
);

    logic [31:0] w_shift;

    assign w_shift = i_mem_rdata >> {i_rsp_lo, 3'b000};

    always_comb begin
        o_be       = 4'b0000;
        o_wdata    = 32'd0;
        o_misalign = 1'b0;
        case (i_req_f3)
            F3_B, F3_BU: begin
                o_be    = 4'b0001 << i_req_lo;
                o_wdata = {4{i_alu_out[7:0]}};
            end
            F3_H, F3_HU: begin
                o_be       = 4'b0011 << i_req_lo;
                o_wdata    = {2{i_alu_out[15:0]}};
                o_misalign = i_req_lo[0];
            end
            F3_W: begin
                o_be       = 4'b1111;
                o_wdata    = i_alu_out;
                o_misalign = (i_req_lo != 2'b00);
            end
            default: o_misalign = 1'b1;
        endcase
        // Unsigned widths only make sense for loads.
        if (i_is_store && (i_req_f3 == F3_BU || i_req_f3 == F3_HU))
            o_misalign = 1'b1;
    end

    always_comb begin
        o_load_data = w_shift;
        case (i_rsp_f3)
            F3_B:    o_load_data = {{24{w_shift[7]}}, w_shift[7:0]};
            F3_H:    o_load_data = {{16{w_shift[15]}}, w_shift[15:0]};
            F3_BU:   o_load_data = {24'd0, w_shift[7:0]};
            F3_HU:   o_load_data = {16'd0, w_shift[15:0]};
            default: o_load_data = w_shift;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Brief    : Memory-access stage: req/ack loads/stores and registered writeback.
//            Optional ack watchdog enabled by defining LSU_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit
    import rv32_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic [31:0] alu_out,
    input  wire logic [31:0] d_add,
    input  wire logic        d_r_en,
    input  wire logic        d_w_en,
    input  wire logic [2:0]  f3,
    input  wire logic [4:0]  alu_rd,
    input  wire logic        alu_reg_w_en,
    load_store_unit_if.master mem,
    output logic             lsu_busy,
    output logic             wb_we,
    output logic      [4:0]  wb_rd,
    output logic      [31:0] wb_data,
    output logic             lsu_err
);

    lsu_state_t  r_state;
    logic        r_req;
    logic        r_we;
    logic [31:0] r_addr;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic [2:0]  r_f3;
    logic [1:0]  r_lo;
    logic [4:0]  r_rd;
    logic        r_busy;
    logic        r_wb_we;
    logic [4:0]  r_wb_rd;
    logic [31:0] r_wb_data;
    logic        r_err;

    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic        w_misalign;
    logic [31:0] w_load_data;
    logic        w_timeout;

    lsu_align u_align (
        .i_req_f3    (f3),
        .i_req_lo    (d_add[1:0]),
        .i_is_store  (d_w_en),
        .i_alu_out   (alu_out),
        .o_be        (w_be),
        .o_wdata     (w_wdata),
        .o_misalign  (w_misalign),
        .i_rsp_f3    (r_f3),
        .i_rsp_lo    (r_lo),
        .i_mem_rdata (mem.mem_rdata),
        .o_load_data (w_load_data)
    );

`ifdef LSU_TIMEOUT_EN
    logic [31:0] r_tmo_cnt;

    // Ack on the expiring edge takes priority over the timeout.
    assign w_timeout = (r_state == ST_ACCESS) && !mem.mem_ack &&
                       (r_tmo_cnt == 32'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_tmo_cnt <= 32'd0;
        else if (r_state != ST_ACCESS)
            r_tmo_cnt <= 32'd0;
        else if (!mem.mem_ack)
            r_tmo_cnt <= r_tmo_cnt + 32'd1;
    end
`else
    // Keeps the parameter referenced in builds without the watchdog.
    assign w_timeout = (TIMEOUT < 0);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_req     <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= 32'd0;
            r_be      <= 4'd0;
            r_wdata   <= 32'd0;
            r_f3      <= 3'd0;
            r_lo      <= 2'd0;
            r_rd      <= 5'd0;
            r_busy    <= 1'b0;
            r_wb_we   <= 1'b0;
            r_wb_rd   <= 5'd0;
            r_wb_data <= 32'd0;
            r_err     <= 1'b0;
        end else begin
            r_wb_we <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (d_r_en && d_w_en) begin
                        r_err <= 1'b1;
                    end else if (d_r_en || d_w_en) begin
                        if (w_misalign) begin
                            r_err <= 1'b1;
                        end else begin
                            r_state <= ST_ACCESS;
                            r_req   <= 1'b1;
                            r_busy  <= 1'b1;
                            r_we    <= d_w_en;
                            r_addr  <= {d_add[31:2], 2'b00};
                            r_be    <= w_be;
                            r_wdata <= w_wdata;
                            r_f3    <= f3;
                            r_lo    <= d_add[1:0];
                            r_rd    <= alu_rd;
                        end
                    end else if (alu_reg_w_en && alu_rd != 5'd0) begin
                        r_wb_we   <= 1'b1;
                        r_wb_rd   <= alu_rd;
                        r_wb_data <= alu_out;
                    end
                end
                ST_ACCESS: begin
                    if (mem.mem_ack) begin
                        r_state <= ST_IDLE;
                        r_req   <= 1'b0;
                        r_busy  <= 1'b0;
                        if (!r_we && r_rd != 5'd0) begin
                            r_wb_we   <= 1'b1;
                            r_wb_rd   <= r_rd;
                            r_wb_data <= w_load_data;
                        end
                    end else if (w_timeout) begin
                        r_state <= ST_IDLE;
                        r_req   <= 1'b0;
                        r_busy  <= 1'b0;
                        r_err   <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign mem.mem_req   = r_req;
    assign mem.mem_we    = r_we;
    assign mem.mem_addr  = r_addr;
    assign mem.mem_be    = r_be;
    assign mem.mem_wdata = r_wdata;
    assign lsu_busy      = r_busy;
    assign wb_we         = r_wb_we;
    assign wb_rd         = r_wb_rd;
    assign wb_data       = r_wb_data;
    assign lsu_err       = r_err;

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage directly downstream of the ALU stage. Consumes the ALU's registered outputs (`alu_out`, `d_add`, `d_r_en`, `d_w_en`, `f3`, `alu_rd`, `alu_reg_w_en`) and runs loads and stores against a data memory over a req/ack handshake. Performs byte-lane steering, sign/zero extension and alignment checking. Produces the registered writeback (`wb_*`) consumed by the register file.

## Interface
- `TIMEOUT`, 16: ack watchdog limit in cycles; used only with `LSU_TIMEOUT_EN`.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `alu_out` in 32: store data (low lanes) or non-memory result.
- `d_add` in 32: byte address of the memory access.
- `d_r_en` in 1: load request.
- `d_w_en` in 1: store request.
- `f3` in 3: width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `alu_rd` in 5: destination register.
- `alu_reg_w_en` in 1: register write request.
- `mem_req` out 1: memory request, held until ack.
- `mem_we` out 1: 1 = store.
- `mem_addr` out 32: word address, `{d_add[31:2],2'b00}`.
- `mem_be` out 4: byte enables.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_rdata` in 32: load data, valid with `mem_ack`.
- `mem_ack` in 1: one-cycle completion strobe.
- `lsu_busy` out 1: stall to upstream; inputs are ignored while high.
- `wb_we` out 1: register-file write strobe.
- `wb_rd` out 5: writeback register.
- `wb_data` out 32: writeback data.
- `lsu_err` out 1: one-cycle pulse on misaligned or illegal access (also on timeout when enabled).

## Operation
- **States.** Two states: IDLE and ACCESS. Sampling happens only in IDLE.
- **Non-memory op** (`d_r_en=d_w_en=0`):
  - Next cycle: `wb_we=alu_reg_w_en && alu_rd!=0`, `wb_rd=alu_rd`, `wb_data=alu_out`.
- **Illegal op** (`d_r_en=d_w_en=1`, as the ALU emits on unknown opcodes):
  - No access, `wb_we=0`, `lsu_err` pulse.
- **Misaligned access** (H with `d_add[0]=1`, W with `d_add[1:0]!=0`, or `f3` in {011, 110, 111}):
  - No access, `wb_we=0`, `lsu_err` pulse.
  - Stores with `f3` in {100, 101} are also illegal.
- **Legal access:**
  - Latch the request, drive `mem_req=1` next cycle, go to ACCESS.
  - `mem_be`: B gives `4'b0001<<d_add[1:0]`; H gives `4'b0011<<d_add[1:0]`; W gives `4'b1111`.
  - `mem_wdata`: B gives `{4{alu_out[7:0]}}`; H gives `{2{alu_out[15:0]}}`; W gives `alu_out`.
- **ACCESS:**
  - `mem_req`, `mem_we`, `mem_addr`, `mem_be` and `mem_wdata` are held stable until `mem_ack` is sampled high.
  - On ack, the next cycle has `mem_req=0` and state IDLE.
  - For a load, that same next cycle also has `wb_we=(rd!=0)`, `wb_rd=rd`, and `wb_data` = selected lane (`mem_rdata >> 8*d_add[1:0]`), sign-extended for B/H and zero-extended for BU/HU.
  - Stores never write back.
- **Ignored ack:** `mem_ack` in IDLE is ignored.
- **Writeback strobe:** `wb_we` and `lsu_err` are single-cycle; `wb_rd`/`wb_data` hold their last values.
- **Reset.** Asserting `rst` forces IDLE immediately, including mid-ACCESS. The in-flight access is dropped and no writeback occurs for it. Every output resets to 0.

## Timing
- Non-memory latency: 1 cycle (inputs at edge N give `wb_*` at N+1).
- Load latency: request captured at edge N, `mem_req` high from N+1, ack sampled at edge A, `wb_we` high for one cycle after edge A. Minimum total is 2 cycles, with ack in the first cycle of request.
- `lsu_busy` is registered and equals (state == ACCESS). It is high from N+1 through the ack edge.
- The ALU result presented in the same cycle as a capture is processed. Results presented while `lsu_busy`=1 are dropped; upstream must hold.
- Back-to-back: a new request may be captured at the edge after ack, with no bubble beyond the IDLE cycle.

## Configuration
- **`LSU_TIMEOUT_EN` defined:**
  - A counter runs in ACCESS.
  - If `TIMEOUT` cycles elapse without ack: drop `mem_req`, return to IDLE, pulse `lsu_err`, no writeback.
  - An ack arriving on the same edge as the timeout wins.
- **`LSU_TIMEOUT_EN` not defined:**
  - No counter logic; ACCESS waits indefinitely.

## Structure
- **Shared package `rv32_pkg`:**
  - `f3` width codes (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`).
  - The state enum.
- **Sub-module `lsu_align`:**
  - Combinational: produces `mem_be` and `mem_wdata` from (`f3`, `addr[1:0]`, `alu_out`).
  - Produces extended load data from (`f3`, `addr[1:0]`, `mem_rdata`).
  - Produces the misalign flag.
- **Top level:** FSM, latches, watchdog.

## Test plan
- **Non-memory op:** `alu_out=0x1234`, `alu_rd=5`, `alu_reg_w_en=1` → next cycle `wb_we=1`, `wb_rd=5`, `wb_data=0x1234`, `mem_req=0`.
- **LB:** `d_add=0x103`, `f3=000`, `rd=7`, ack after 3 cycles with `mem_rdata=0x80FF_0000` → `mem_addr=0x100`, `mem_be=0001<<3`, `wb_data=0xFFFF_FF80`. Same with `f3=100` → `0x0000_0080`.
- **SH:** `d_add=0x22`, `alu_out=0xDEAD_BEEF` → `mem_be=1100`, `mem_wdata=0xBEEF_BEEF`, `wb_we` stays 0.
- **Misaligned LW / illegal op:** LW at `0x41` → `lsu_err` pulse, no `mem_req`. Both enables high → `lsu_err` pulse, no writeback.
- **Reset mid-ACCESS:** `rst` low during ACCESS → `mem_req`, `lsu_busy` and `wb_we` go to 0 at once. A later `mem_ack` is ignored.
- **Timeout (`LSU_TIMEOUT_EN`, `TIMEOUT=4`):** no ack → `mem_req` drops after 4 cycles and `lsu_err` pulses. Ack on cycle 4 → normal writeback.
